fsm_ringmonitor4: RTL and testbench
===================================

// Module: fsm_ringmonitor4
// PURPOSE
//  Receive-side checker/decoder for the 4-state one-hot ring sequence emitted by the
//  ring counter (ring_in[N-1] = 1st state ... ring_in[0] = last state). Decodes the
//  one-hot vector to a binary index, validates every transition (hold or +1 mod N),
//  pulses on each step and counts completed laps. Sits at the consumer end of the link.
// PARAMETERS
//  N      4  ring length / ring_in width (N >= 2)
//  LAP_W  8  width of lap counter
//  IDX_W  2  index width, fixed = $clog2(N)
// PORTS
//  clk        in   1      system clock, all flops rising-edge
//  reset      in   1      asynchronous, active-low reset
//  clear      in   1      sync: return to HUNT, zero lap_count (priority over all events)
//  ring_in    in   N      one-hot ring vector from producer
//  index_out  out  IDX_W  decoded position: 0 when ring_in[N-1] set ... N-1 when ring_in[0] set
//  valid      out  1      index_out meaningful (state LOCKED)
//  step       out  1      1-cycle pulse: legal advance observed
//  lap_count  out  LAP_W  completed laps (N-1 -> 0 advances), wraps modulo 2^LAP_W
//  onehot_err out  1      1-cycle pulse: non-one-hot sample while LOCKED
//  seq_err    out  1      1-cycle pulse: legal one-hot but illegal jump while LOCKED
//  fault      out  1      level, state FAULT
// BEHAVIOUR
//  - Reset (reset=0, async): state HUNT, sample reg = 0, all outputs 0.
//  - Pipeline: ring_in registered into smp at edge k; FSM/outputs update from smp at
//    edge k+1. All outputs registered. Latency ring_in -> outputs = 2 clock edges.
//  - States (Moore for valid/fault, pulses registered):
//    HUNT:   smp one-hot -> capture idx, LOCKED (valid=1). Else stay, no error raised.
//    LOCKED: new idx == prev -> hold, no pulse.
//            new idx == (prev+1) mod N -> step=1, index_out=new; if prev==N-1 also
//            lap_count+1 (wrap 2^LAP_W-1 -> 0 silently).
//            other one-hot -> seq_err=1, FAULT.  non-one-hot (0 or >1 bits) -> onehot_err=1, FAULT.
//    FAULT:  valid=0, fault=1, index_out holds last good value, lap_count frozen;
//            sticky until clear.
//  - clear=1: next state HUNT, lap_count=0, valid/fault/pulses=0 next cycle; wins
//    over simultaneous error or wrap. smp still samples during clear.
//  - Reset mid-operation: immediate return to reset values regardless of state.
//  - Backward step (idx-1) is a seq_err; only forward direction legal.
//  - Pulses never overlap: at most one of step/onehot_err/seq_err per cycle.
// STRUCTURE
//  - Shared package/include: state encoding localparams (HUNT=2'b00, LOCKED=2'b01,
//    FAULT=2'b10), IDX_W derivation.
//  - One sub-module: ring_onehot_dec (combinational: vec[N] -> idx[IDX_W], is_onehot).
//  - Top: sample reg, state reg, next-state logic, prev-idx reg, lap counter.
// TESTING
//  1 reset=0 then 1, ring_in=4'b0000 x5 cycles -> valid=0, fault=0, no pulses (HUNT).
//  2 ring_in 1000,0100,0010,0001,1000 one per cycle -> step x4, index 0..3..0, lap_count=1.
//  3 ring_in held 0100 for 3 cycles while LOCKED -> index_out=1, no step, valid stays 1.
//  4 LOCKED at 0100, drive 0001 -> seq_err 1 cycle, fault=1, valid=0; clear=1 -> HUNT, lap_count=0.
//  5 LOCKED, drive 0110 -> onehot_err 1 cycle, fault=1; drive legal vectors -> stays FAULT.
//  6 LAP_W=2, run 4 full laps -> lap_count 1,2,3,0; assert reset=0 mid-lap -> all outputs 0 at once.

Source files
------------

// File: rtl/fsm_ringmonitor4_pkg.sv
// Shared definitions for the ring-sequence monitor: FSM state encoding and
// index-width derivation.
package fsm_ringmonitor4_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'b00,
    LOCKED = 2'b01,
    FAULT  = 2'b10
  } state_e;

  localparam int RING_N_DEFAULT = 4;

  // A 2-entry ring still needs one index bit, so clamp the lower end.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ring_onehot_dec.sv
// Combinational one-hot decoder: vec[N-1] maps to index 0, vec[0] to index N-1.
module ring_onehot_dec #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     vec,
  output logic [IDX_W-1:0] idx,
  output logic             is_onehot
);

  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (vec[N-1-i]) idx = IDX_W'(i);
    end
  end

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  assign is_onehot = (vec != '0) && ((vec & (vec - N'(1))) == '0);

endmodule

// File: rtl/fsm_ringmonitor4.sv
// Receive-side checker for a one-hot ring sequence: decodes position, validates
// hold/forward-step transitions, pulses on steps and errors, counts laps.
module fsm_ringmonitor4
  import fsm_ringmonitor4_pkg::*;
#(
  parameter int N     = RING_N_DEFAULT,
  parameter int LAP_W = 8,
  localparam int IDX_W = idx_width(N)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [N-1:0]     ring_in,
  output logic [IDX_W-1:0] index_out,
  output logic             valid,
  output logic             step,
  output logic [LAP_W-1:0] lap_count,
  output logic             onehot_err,
  output logic             seq_err,
  output logic             fault,
  output logic [1:0]       state_dbg
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  logic [N-1:0]     smp_q;
  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [LAP_W-1:0] lap_q, lap_d;
  logic             step_q, step_d;
  logic             oh_err_q, oh_err_d;
  logic             seq_err_q, seq_err_d;

  logic [IDX_W-1:0] dec_idx;
  logic             dec_onehot;
  logic [IDX_W-1:0] next_idx;

  ring_onehot_dec #(.N(N), .IDX_W(IDX_W)) u_dec (
    .vec       (smp_q),
    .idx       (dec_idx),
    .is_onehot (dec_onehot)
  );

  // Forward neighbour of the last accepted position, wrapping at N.
  assign next_idx = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    lap_d     = lap_q;
    step_d    = 1'b0;
    oh_err_d  = 1'b0;
    seq_err_d = 1'b0;
    if (clear) begin
      state_d = HUNT;
      lap_d   = '0;
    end else begin
      case (state_q)
        HUNT: begin
          if (dec_onehot) begin
            idx_d   = dec_idx;
            state_d = LOCKED;
          end
        end
        LOCKED: begin
          if (!dec_onehot) begin
            oh_err_d = 1'b1;
            state_d  = FAULT;
          end else if (dec_idx == next_idx) begin
            step_d = 1'b1;
            idx_d  = dec_idx;
            if (idx_q == LAST_IDX) lap_d = lap_q + LAP_W'(1);
          end else if (dec_idx != idx_q) begin
            seq_err_d = 1'b1;
            state_d   = FAULT;
          end
        end
        FAULT:   state_d = FAULT;
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      smp_q     <= '0;
      state_q   <= HUNT;
      idx_q     <= '0;
      lap_q     <= '0;
      step_q    <= 1'b0;
      oh_err_q  <= 1'b0;
      seq_err_q <= 1'b0;
    end else begin
      smp_q     <= ring_in;
      state_q   <= state_d;
      idx_q     <= idx_d;
      lap_q     <= lap_d;
      step_q    <= step_d;
      oh_err_q  <= oh_err_d;
      seq_err_q <= seq_err_d;
    end
  end

  assign index_out  = idx_q;
  assign valid      = (state_q == LOCKED);
  assign fault      = (state_q == FAULT);
  assign step       = step_q;
  assign lap_count  = lap_q;
  assign onehot_err = oh_err_q;
  assign seq_err    = seq_err_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_fsm_ringmonitor4.sv
// Directed bench for fsm_ringmonitor4: vector table plus hand sequences for
// clear-vs-wrap priority, lap wrap with a 2-bit counter and async reset.
module tb_fsm_ringmonitor4;

  logic       clk;
  logic       reset;
  logic       clear;
  logic [3:0] ring_in;

  logic [1:0] idx8, idx2;
  logic       valid8, step8, oh8, seq8, fault8;
  logic       valid2, step2, oh2, seq2, fault2;
  logic [7:0] lap8;
  logic [1:0] lap2;
  logic [1:0] st8, st2;

  fsm_ringmonitor4 #(.N(4), .LAP_W(8)) dut8 (
    .clk(clk), .reset(reset), .clear(clear), .ring_in(ring_in),
    .index_out(idx8), .valid(valid8), .step(step8), .lap_count(lap8),
    .onehot_err(oh8), .seq_err(seq8), .fault(fault8), .state_dbg(st8)
  );

  fsm_ringmonitor4 #(.N(4), .LAP_W(2)) dut2 (
    .clk(clk), .reset(reset), .clear(clear), .ring_in(ring_in),
    .index_out(idx2), .valid(valid2), .step(step2), .lap_count(lap2),
    .onehot_err(oh2), .seq_err(seq2), .fault(fault2), .state_dbg(st2)
  );

  // clock/reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       clr;
    logic [3:0] ring;
    logic       valid, fault, step, oh, seq;
    logic [1:0] idx;
    logic [7:0] lap;
  } row_t;

  row_t        rows[$];
  logic [14:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;

  task automatic add(input logic c, input logic [3:0] r, input logic v, input logic f,
                     input logic s, input logic o, input logic q, input logic [1:0] i,
                     input logic [7:0] l);
    row_t t;
    t.clr = c; t.ring = r; t.valid = v; t.fault = f; t.step = s;
    t.oh = o; t.seq = q; t.idx = i; t.lap = l;
    rows.push_back(t);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // driver: apply inputs, advance one edge, settle before sampling
  task automatic drive(input logic c, input logic [3:0] r);
    clear   = c;
    ring_in = r;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [14:0] pack8();
    return {valid8, fault8, step8, oh8, seq8, idx8, lap8};
  endfunction

  initial begin
    int exp_lap;
    logic [3:0] v;

    // Expected outputs sampled after the edge that follows each row's inputs;
    // ring_in reaches the FSM one edge later, clear acts on the same edge.
    for (int i = 0; i < 5; i++) add(0, 4'b0000, 0,0,0,0,0, 2'd0, 8'd0);
    add(0, 4'b1000, 0,0,0,0,0, 2'd0, 8'd0);
    add(0, 4'b0100, 1,0,0,0,0, 2'd0, 8'd0);
    add(0, 4'b0010, 1,0,1,0,0, 2'd1, 8'd0);
    add(0, 4'b0001, 1,0,1,0,0, 2'd2, 8'd0);
    add(0, 4'b1000, 1,0,1,0,0, 2'd3, 8'd0);
    add(0, 4'b0100, 1,0,1,0,0, 2'd0, 8'd1);
    add(0, 4'b0100, 1,0,1,0,0, 2'd1, 8'd1);
    add(0, 4'b0100, 1,0,0,0,0, 2'd1, 8'd1);
    add(0, 4'b0100, 1,0,0,0,0, 2'd1, 8'd1);
    add(0, 4'b0001, 1,0,0,0,0, 2'd1, 8'd1);
    add(0, 4'b0001, 0,1,0,0,1, 2'd1, 8'd1);
    add(0, 4'b0001, 0,1,0,0,0, 2'd1, 8'd1);
    add(1, 4'b0001, 0,0,0,0,0, 2'd1, 8'd0);
    add(0, 4'b1000, 1,0,0,0,0, 2'd3, 8'd0);
    add(0, 4'b1000, 1,0,1,0,0, 2'd0, 8'd1);
    add(0, 4'b0110, 1,0,0,0,0, 2'd0, 8'd1);
    add(0, 4'b0100, 0,1,0,1,0, 2'd0, 8'd1);
    add(0, 4'b0010, 0,1,0,0,0, 2'd0, 8'd1);
    add(0, 4'b0001, 0,1,0,0,0, 2'd0, 8'd1);
    add(1, 4'b0000, 0,0,0,0,0, 2'd0, 8'd0);
    add(0, 4'b1000, 0,0,0,0,0, 2'd0, 8'd0);
    add(0, 4'b0100, 1,0,0,0,0, 2'd0, 8'd0);
    add(0, 4'b0000, 1,0,1,0,0, 2'd1, 8'd0);
    add(0, 4'b0000, 0,1,0,1,0, 2'd1, 8'd0);
    add(1, 4'b0000, 0,0,0,0,0, 2'd1, 8'd0);
    add(0, 4'b0100, 0,0,0,0,0, 2'd1, 8'd0);
    add(0, 4'b1000, 1,0,0,0,0, 2'd1, 8'd0);
    add(0, 4'b1000, 0,1,0,0,1, 2'd1, 8'd0);
    add(1, 4'b0000, 0,0,0,0,0, 2'd1, 8'd0);

    reset   = 1'b1;
    clear   = 1'b0;
    ring_in = 4'b0000;
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {17'd0, pack8()}, 32'd0);
    check("reset_state", {30'd0, st8}, 32'd0);
    reset = 1'b1;

    foreach (rows[i]) begin
      exp_q.push_back({rows[i].valid, rows[i].fault, rows[i].step, rows[i].oh,
                       rows[i].seq, rows[i].idx, rows[i].lap});
      drive(rows[i].clr, rows[i].ring);
      check($sformatf("row%0d", i), {17'd0, pack8()}, {17'd0, exp_q.pop_front()});
    end

    // clear on the same edge as a would-be wrap step: clear wins
    drive(0, 4'b0001);
    drive(0, 4'b1000);
    check("lock_at_last", {29'd0, valid8, idx8}, {29'd0, 1'b1, 2'd3});
    drive(1, 4'b0000);
    check("clear_beats_wrap", {22'd0, valid8, step8, lap8}, 32'd0);
    check("clear_idx_hold", {30'd0, idx8}, 32'd3);

    // four full laps; the 2-bit counter wraps back to zero
    exp_lap = 0;
    for (int k = 0; k < 18; k++) begin
      v = 4'b1000 >> (k % 4);
      drive(0, v);
      if (k >= 2 && ((k - 1) % 4) == 0) exp_lap++;
      if (k >= 1) begin
        check($sformatf("lap_run%0d", k), {27'd0, valid2, step2, idx2, lap2},
              {27'd0, 1'b1, (k >= 2), 2'((k - 1) % 4), 2'(exp_lap)});
      end
    end
    check("lap8_after4", {24'd0, lap8}, 32'd4);
    check("lap2_wrapped", {30'd0, lap2}, 32'd0);

    // async reset mid-lap takes effect without waiting for a clock edge
    reset = 1'b0;
    #2;
    check("midlap_reset8", {17'd0, pack8()}, 32'd0);
    check("midlap_reset2", {22'd0, valid2, fault2, step2, oh2, seq2, idx2, lap2, st2}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    drive(0, 4'b1000);
    check("post_reset_hunt", {17'd0, pack8()}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
